// File: rtl/proc_sequencer.sv
// proc_sequencer: fetch/decode/execute controller; an instruction takes 2 cycles with a zero-wait fetch, and OUT takes at least 3.
// Stalls in FETCH until imem_ack and in OUTWAIT until out_ready. Define PROC_SEQ_ILLEGAL_TRAP_EN to trap on undefined opcodes.
module proc_sequencer #(
  parameter int PC_WIDTH = 4
) (
  input  logic                clk,
  input  logic                reset_n,
  output logic                imem_req,
  output logic [PC_WIDTH-1:0] imem_addr,
  input  logic                imem_ack,
  input  logic [7:0]          imem_rdata,
  output logic [3:0]          alu_a,
  output logic [3:0]          alu_b,
  output logic                alu_sub,
  input  logic [3:0]          alu_result,
  output logic                out_valid,
  output logic [3:0]          out_data,
  input  logic                out_ready,
  output logic                halted,
  output logic                illegal
);

  typedef enum logic [2:0] {S_START, S_FETCH, S_EXEC, S_OUTWAIT, S_HALT} state_t;

  localparam logic [3:0] OP_NOP  = 4'h0;
  localparam logic [3:0] OP_LDI  = 4'h1;
  localparam logic [3:0] OP_ADDI = 4'h2;
  localparam logic [3:0] OP_SUBI = 4'h3;
  localparam logic [3:0] OP_JMP  = 4'h4;
  localparam logic [3:0] OP_JZ   = 4'h5;
  localparam logic [3:0] OP_OUT  = 4'h6;
  localparam logic [3:0] OP_HALT = 4'hF;

  state_t              state, state_n;
  logic [PC_WIDTH-1:0] pc, pc_n, pc_inc, imm_ext;
  logic [3:0]          acc, acc_n, out_q, out_n;
  logic [7:0]          ir, ir_n;
  logic                z, z_n;

  assign pc_inc  = pc + PC_WIDTH'(1);
  assign imm_ext = PC_WIDTH'(ir[3:0]);

  assign imem_req  = (state == S_FETCH);
  assign imem_addr = pc;
  assign out_valid = (state == S_OUTWAIT);
  assign out_data  = out_q;
  assign halted    = (state == S_HALT);
  assign alu_a     = acc;
  assign alu_b     = ir[3:0];
  assign alu_sub   = (ir[7:4] == OP_SUBI);

`ifdef PROC_SEQ_ILLEGAL_TRAP_EN
  logic ill_q, ill_n;
  assign illegal = ill_q;
`else
  assign illegal = 1'b0;
`endif

  always_comb begin
    state_n = state;
    pc_n    = pc;
    acc_n   = acc;
    z_n     = z;
    ir_n    = ir;
    out_n   = out_q;
`ifdef PROC_SEQ_ILLEGAL_TRAP_EN
    ill_n   = ill_q;
`endif
    case (state)
      S_START: state_n = S_FETCH;
      S_FETCH: begin
        if (imem_ack) begin
          ir_n    = imem_rdata;
          state_n = S_EXEC;
        end
      end
      S_EXEC: begin
        state_n = S_FETCH;
        case (ir[7:4])
          OP_NOP: pc_n = pc_inc;
          OP_LDI: begin
            acc_n = ir[3:0];
            z_n   = (ir[3:0] == 4'd0);
            pc_n  = pc_inc;
          end
          OP_ADDI, OP_SUBI: begin
            acc_n = alu_result;
            z_n   = (alu_result == 4'd0);
            pc_n  = pc_inc;
          end
          OP_JMP: pc_n = imm_ext;
          OP_JZ:  pc_n = z ? imm_ext : pc_inc;
          // PC advances only once the output handshake completes
          OP_OUT: begin
            out_n   = acc;
            state_n = S_OUTWAIT;
          end
          OP_HALT: state_n = S_HALT;
          default: begin
`ifdef PROC_SEQ_ILLEGAL_TRAP_EN
            ill_n   = 1'b1;
            state_n = S_HALT;
`else
            pc_n = pc_inc;
`endif
          end
        endcase
      end
      S_OUTWAIT: begin
        if (out_ready) begin
          pc_n    = pc_inc;
          state_n = S_FETCH;
        end
      end
      S_HALT:  state_n = S_HALT;
      default: state_n = S_START;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= S_START;
      pc    <= '0;
      acc   <= '0;
      z     <= 1'b0;
      ir    <= '0;
      out_q <= '0;
    end else begin
      state <= state_n;
      pc    <= pc_n;
      acc   <= acc_n;
      z     <= z_n;
      ir    <= ir_n;
      out_q <= out_n;
    end
  end

`ifdef PROC_SEQ_ILLEGAL_TRAP_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) ill_q <= 1'b0;
    else          ill_q <= ill_n;
  end
`endif

endmodule

// File: tb/tb_proc_sequencer.sv
// Bench for proc_sequencer: an ISA-level model fills fetch/output scoreboards that a
// negedge monitor drains while the bench plays instruction memory, ALU and output consumer.
module tb_proc_sequencer;

  typedef struct { logic [3:0] addr; logic [3:0] acc; } fetch_t;
  typedef struct { logic [3:0] pc;   logic [3:0] data; } outx_t;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       imem_req, imem_ack, alu_sub, out_valid, out_ready, halted, illegal;
  logic [3:0] imem_addr, alu_a, alu_b, alu_result, out_data;
  logic [7:0] imem_rdata;

  logic [7:0] mem [16];
  int         ack_delay = 0, rdy_delay = 0, wcnt = 0, vcnt = 0;
  int         tests = 0, fails = 0;
  int         cyc = 0, first_req = -1, halt_cyc = -1, vlen = 0, last_vlen = 0;
  bit         strict = 1'b1, exec_nxt = 1'b0, exp_halt = 1'b0, exp_ill = 1'b0;
  logic [3:0] ex_op, ex_imm;
  fetch_t     exp_f[$];
  outx_t      exp_o[$];

  always #5 clk = ~clk;

  proc_sequencer #(.PC_WIDTH(4)) dut (
    .clk(clk), .reset_n(reset_n),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .alu_a(alu_a), .alu_b(alu_b), .alu_sub(alu_sub), .alu_result(alu_result),
    .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
    .halted(halted), .illegal(illegal)
  );

  // Memory, ALU and consumer responders
  assign imem_rdata = mem[imem_addr];
  assign imem_ack   = imem_req && (wcnt >= ack_delay);
  assign alu_result = alu_sub ? (alu_a - alu_b) : (alu_a + alu_b);
  assign out_ready  = (vcnt >= rdy_delay);

  always @(posedge clk) begin
    wcnt <= (imem_req && !imem_ack) ? wcnt + 1 : 0;
    vcnt <= out_valid ? vcnt + 1 : 0;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_run(input int max_f);
    logic [3:0] pc, acc, op, imm;
    logic       z;
    fetch_t     f;
    outx_t      o;
    pc = 4'd0; acc = 4'd0; z = 1'b0; exp_halt = 1'b0; exp_ill = 1'b0;
    for (int i = 0; i < max_f && !exp_halt; i++) begin
      op = mem[pc][7:4];
      imm = mem[pc][3:0];
      f.addr = pc; f.acc = acc;
      exp_f.push_back(f);
      case (op)
        4'h0: pc = pc + 4'd1;
        4'h1: begin acc = imm; z = (imm == 4'd0); pc = pc + 4'd1; end
        4'h2: begin acc = acc + imm; z = (acc == 4'd0); pc = pc + 4'd1; end
        4'h3: begin acc = acc - imm; z = (acc == 4'd0); pc = pc + 4'd1; end
        4'h4: pc = imm;
        4'h5: pc = z ? imm : pc + 4'd1;
        4'h6: begin o.pc = pc; o.data = acc; exp_o.push_back(o); pc = pc + 4'd1; end
        4'hF: exp_halt = 1'b1;
        default: begin
`ifdef PROC_SEQ_ILLEGAL_TRAP_EN
          exp_halt = 1'b1;
          exp_ill  = 1'b1;
`else
          pc = pc + 4'd1;
`endif
        end
      endcase
    end
  endtask

  // Monitor: drains the scoreboards as the DUT fetches and emits
  always @(negedge clk) begin
    cyc++;
    if (reset_n) begin
      if (exec_nxt) begin
        check("exec_alu_sub", alu_sub, ex_op == 4'h3);
        check("exec_alu_b", alu_b, ex_imm);
        exec_nxt = 1'b0;
      end
      if (imem_req) begin
        if (first_req < 0) first_req = cyc;
        if (exp_f.size() > 0) begin
          check("fetch_addr", imem_addr, exp_f[0].addr);
          if (imem_ack) begin
            check("acc_at_fetch", alu_a, exp_f[0].acc);
            void'(exp_f.pop_front());
            ex_op    = imem_rdata[7:4];
            ex_imm   = imem_rdata[3:0];
            exec_nxt = 1'b1;
          end
        end else if (strict) begin
          check("extra_fetch", imem_ack, 1'b0);
        end
      end
      if (halted && halt_cyc < 0) halt_cyc = cyc;
      if (out_valid) begin
        vlen++;
        if (exp_o.size() > 0) begin
          check("out_data", out_data, exp_o[0].data);
          check("pc_hold", imem_addr, exp_o[0].pc);
          if (out_ready) void'(exp_o.pop_front());
        end else begin
          check("extra_out", out_valid, 1'b0);
        end
      end else if (vlen > 0) begin
        last_vlen = vlen;
        vlen = 0;
      end
    end
  end

  task automatic fill(input logic [7:0] v);
    for (int i = 0; i < 16; i++) mem[i] = v;
  endtask

  task automatic check_reset_outs();
    check("rst_imem_req", imem_req, 1'b0);
    check("rst_imem_addr", imem_addr, 4'd0);
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_out_data", out_data, 4'd0);
    check("rst_halted", halted, 1'b0);
    check("rst_illegal", illegal, 1'b0);
    check("rst_alu_a", alu_a, 4'd0);
    check("rst_alu_b", alu_b, 4'd0);
    check("rst_alu_sub", alu_sub, 1'b0);
  endtask

  task automatic start_prog(input int dly, input int rdy, input bit strk, input int max_f);
    reset_n = 1'b0;
    ack_delay = dly; rdy_delay = rdy; strict = strk;
    exp_f.delete(); exp_o.delete();
    exec_nxt = 1'b0; vlen = 0; last_vlen = 0; first_req = -1; halt_cyc = -1;
    model_run(max_f);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic run_prog(input int dly, input int rdy, input bit strk, input int max_f,
                          input int exp_cycles);
    start_prog(dly, rdy, strk, max_f);
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      #1;
      if (strk ? halted : (exp_f.size() == 0)) break;
    end
    if (strk) begin
      check("halted", halted, exp_halt);
      check("illegal", illegal, exp_ill);
      if (exp_cycles > 0) check("cycles", halt_cyc - first_req, exp_cycles);
    end
    check("fetch_left", exp_f.size(), 0);
    check("out_left", exp_o.size(), 0);
  endtask

  initial begin
    #1;
    check_reset_outs();

    // LDI 5, ADDI 3, OUT, HALT with zero-wait memory
    fill(8'hF0);
    mem[0] = 8'h15; mem[1] = 8'h23; mem[2] = 8'h60; mem[3] = 8'hF0;
    run_prog(0, 0, 1'b1, 64, 9);
    check("out_pulse_len", last_vlen, 1);

    // Same program with 3 wait cycles on every fetch
    run_prog(3, 0, 1'b1, 64, 21);

    // Subtract wrap, JZ not taken then taken
    fill(8'hF0);
    mem[0] = 8'h12; mem[1] = 8'h33; mem[2] = 8'h60; mem[3] = 8'h5E;
    mem[4] = 8'h13; mem[5] = 8'h33; mem[6] = 8'h5A; mem[10] = 8'h60;
    run_prog(0, 0, 1'b1, 64, 0);

    // Consumer stalls for 4 cycles
    fill(8'hF0);
    mem[0] = 8'h19; mem[1] = 8'h60;
    run_prog(0, 4, 1'b1, 64, 0);
    check("stall_valid_len", last_vlen, 5);

    // 16 NOPs then PC wraps to 0
    fill(8'h00);
    run_prog(0, 0, 1'b0, 17, 0);

    // JMP 7
    fill(8'h00);
    mem[0] = 8'h47; mem[7] = 8'hF0;
    run_prog(1, 0, 1'b1, 64, 0);

    // Undefined opcode 0x9
    fill(8'hF0);
    mem[0] = 8'h14; mem[1] = 8'h90; mem[2] = 8'h60;
    run_prog(0, 0, 1'b1, 64, 0);
    check("acc_after_undef", alu_a, 4'd4);

    // Reset pulsed while waiting in OUTWAIT
    fill(8'hF0);
    mem[0] = 8'h16; mem[1] = 8'h60;
    start_prog(0, 1000, 1'b1, 64);
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      #1;
      if (out_valid) break;
    end
    check("outwait_reached", out_valid, 1'b1);
    reset_n = 1'b0;
    #1;
    check_reset_outs();
    exp_f.delete(); exp_o.delete();
    repeat (2) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
